term_fifo_bank: RTL and testbench
=================================

# term_fifo_bank

Parametrised bank of NUM_CH independent terminal FIFOs, the successor to the single-channel terminal FIFO that sits between the test environment's drivers/monitors and the mesh router terminals. Each channel buffers PAKG_SIZE-bit packets on a push interface and presents them to the consumer with the router's pending/pop handshake (first-word fall-through). The bank adds what the single FIFO lacks: per-channel occupancy count, almost-full threshold, sticky overflow/underflow flags and per-channel synchronous flush. One instance serves all terminals of a ROWS x COLUMNS mesh (NUM_CH = 2*(ROWS+COLUMNS)).

## Interface
Parameters:
- NUM_CH, 16, number of independent channels (>=1)
- PAKG_SIZE, 32, packet width in bits
- FIFO_DEPTH, 16, entries per channel (>=2, need not be a power of two)
- AFULL_TH, FIFO_DEPTH-2, count at or above which afull_o asserts (1..FIFO_DEPTH)
- CNT_W, $clog2(FIFO_DEPTH+1), width of each count field (derived, not overridden)

Ports (channel c occupies bits [c*W +: W] of packed buses):
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-low
- push_i  in  NUM_CH  write request per channel
- data_in_i  in  NUM_CH*PAKG_SIZE  write data
- pop_i  in  NUM_CH  consume head word per channel
- flush_i  in  NUM_CH  synchronous per-channel clear
- data_out_o  out  NUM_CH*PAKG_SIZE  head word (valid when pndng_o=1)
- pndng_o  out  NUM_CH  channel non-empty
- full_o  out  NUM_CH  count == FIFO_DEPTH
- afull_o  out  NUM_CH  count >= AFULL_TH
- count_o  out  NUM_CH*CNT_W  occupancy
- ovf_o  out  NUM_CH  sticky: push dropped
- udf_o  out  NUM_CH  sticky: pop on empty

## Operation
- Per channel: storage array FIFO_DEPTH x PAKG_SIZE, rd_ptr, wr_ptr (0..FIFO_DEPTH-1, wrap FIFO_DEPTH-1 -> 0), count register 0..FIFO_DEPTH. Channels fully independent; no shared state.
- Reset (rst_i low, async): pointers, count, ovf_o, udf_o = 0 immediately. Outputs: pndng_o=0, full_o=0, afull_o=0 (AFULL_TH>=1), count_o=0, data_out_o=0 (storage is reset to 0). Reset mid-operation discards all contents.
- pop_ok = pop_i & (count != 0). push_ok = push_i & (count != FIFO_DEPTH | pop_ok).
- Push when full with simultaneous valid pop: accepted (count unchanged, both pointers advance).
- Push when full without pop: word dropped, state unchanged, ovf_o set.
- Pop when empty: ignored, udf_o set. Push+pop on empty: push accepted, pop ignored, udf_o set, count -> 1.
- count_next = count + push_ok - pop_ok.
- flush_i has priority over push/pop on that channel in the same cycle: pointers, count, ovf_o, udf_o -> 0; storage contents not cleared; other channels unaffected.
- ovf_o/udf_o clear only on reset or flush.
- Status outputs (pndng_o, full_o, afull_o, count_o) are combinational decodes of the count register only; never of same-cycle push/pop.

## Timing
- data_out_o = mem[rd_ptr], combinational from registers (FWFT).
- Write latency: push in cycle N -> pndng_o and data_out_o valid in N+1 (empty case).
- Pop in cycle N consumes word shown in N; next word (or pndng_o=0) visible in N+1.
- Sustained push+pop every cycle: 1 word/cycle per channel, no bubbles, at any occupancy including full.
- Sticky flags assert in cycle after the offending request.
- No combinational path from any input to any output.

## Test plan
- Reset: drive rst_i=0 mid-traffic with channel 3 at count 5 -> same-cycle all outputs 0; after release channel 3 pndng_o=0, count_o=0.
- Fill/drain ch0: push 0x1..0x10 on consecutive cycles -> count_o 16, full_o=1, afull_o=1 from count 14; pop 16 times -> data 0x1..0x10 in order, pndng_o=0 after last.
- Overflow: ch2 full, push 0xDEAD without pop -> dropped, ovf_o[2]=1, count stays 16; then push 0xBEEF with pop -> accepted, count 16, 0xBEEF emerges as the 16th word after.
- Underflow/simultaneous: ch1 empty, push 0xA5 + pop same cycle -> udf_o[1]=1, next cycle pndng_o[1]=1, data 0xA5, count 1.
- Wrap-around with FIFO_DEPTH=5: 12 push/pop pairs interleaved at occupancy 3 -> in-order data, pointers wrap, count constant 3.
- Flush isolation: ch4 count 7 with ovf_o set, ch5 count 2; flush_i[4] with push_i[4] same cycle -> ch4 count 0, ovf_o[4]=0, pndng_o[4]=0; ch5 unchanged.

Source files
------------

// File: rtl/term_fifo_bank.sv
// rtl/term_fifo_bank.sv - bank of independent first-word-fall-through terminal FIFOs
// Each channel keeps its own storage, pointers, occupancy count and sticky error flags.
module term_fifo_bank #(
  parameter int NUM_CH     = 16,
  parameter int PAKG_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_TH   = FIFO_DEPTH - 2,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CH-1:0]             push_i,
  input  logic [NUM_CH*PAKG_SIZE-1:0]   data_in_i,
  input  logic [NUM_CH-1:0]             pop_i,
  input  logic [NUM_CH-1:0]             flush_i,
  output logic [NUM_CH*PAKG_SIZE-1:0]   data_out_o,
  output logic [NUM_CH-1:0]             pndng_o,
  output logic [NUM_CH-1:0]             full_o,
  output logic [NUM_CH-1:0]             afull_o,
  output logic [NUM_CH*CNT_W-1:0]       count_o,
  output logic [NUM_CH-1:0]             ovf_o,
  output logic [NUM_CH-1:0]             udf_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ovf;
    logic                 udf;
    logic                 pop_ok;
    logic                 push_ok;

    // A pop that frees a slot lets a push into a full channel through.
    assign pop_ok  = pop_i[c] && (count != '0);
    assign push_ok = push_i[c] && ((count != DEPTH_C) || pop_ok);

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else if (flush_i[c]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= data_in_i[c*PAKG_SIZE +: PAKG_SIZE];
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_i[c] && !push_ok) ovf <= 1'b1;
        if (pop_i[c] && !pop_ok)   udf <= 1'b1;
      end
    end

    // Status is decoded from registered state only, never from same-cycle requests.
    assign data_out_o[c*PAKG_SIZE +: PAKG_SIZE] = mem[rd_ptr];
    assign pndng_o[c]                 = (count != '0);
    assign full_o[c]                  = (count == DEPTH_C);
    assign afull_o[c]                 = (count >= AFULL_C);
    assign count_o[c*CNT_W +: CNT_W]  = count;
    assign ovf_o[c]                   = ovf;
    assign udf_o[c]                   = udf;
  end

endmodule

// File: tb/tb_term_fifo_bank.sv
// tb/tb_term_fifo_bank.sv - directed and random checks of term_fifo_bank against a queue model
// Channels 0..5 belong to a depth-16 bank; model slot 6 is a single depth-5 channel.
module tb_term_fifo_bank;

  localparam int NCH = 6;
  localparam int W   = 32;
  localparam int CW  = 5;
  localparam int SCW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   push, pop, flush;
  logic [NCH*W-1:0] din;
  logic [NCH*W-1:0] dout;
  logic [NCH-1:0]   pndng, full, afull, ovf, udf;
  logic [NCH*CW-1:0] cnt;

  logic [0:0]   s_push, s_pop, s_flush;
  logic [W-1:0] s_din, s_dout;
  logic [0:0]   s_pndng, s_full, s_afull, s_ovf, s_udf;
  logic [SCW-1:0] s_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq [7][$];
  bit           movf [7];
  bit           mudf [7];

  always #5 clk = ~clk;

  term_fifo_bank #(.NUM_CH(NCH), .PAKG_SIZE(W), .FIFO_DEPTH(16), .AFULL_TH(14)) dut (
    .clk_i(clk), .rst_i(rst_n), .push_i(push), .data_in_i(din), .pop_i(pop),
    .flush_i(flush), .data_out_o(dout), .pndng_o(pndng), .full_o(full),
    .afull_o(afull), .count_o(cnt), .ovf_o(ovf), .udf_o(udf)
  );

  term_fifo_bank #(.NUM_CH(1), .PAKG_SIZE(W), .FIFO_DEPTH(5), .AFULL_TH(3)) dut5 (
    .clk_i(clk), .rst_i(rst_n), .push_i(s_push), .data_in_i(s_din), .pop_i(s_pop),
    .flush_i(s_flush), .data_out_o(s_dout), .pndng_o(s_pndng), .full_o(s_full),
    .afull_o(s_afull), .count_o(s_cnt), .ovf_o(s_ovf), .udf_o(s_udf)
  );

  task automatic chk(input string tag, input int k, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    push = '0; pop = '0; flush = '0; din = '0;
    s_push = '0; s_pop = '0; s_flush = '0; s_din = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      mudf[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model, from the rules rather than the RTL.
  task automatic model_update();
    for (int k = 0; k < 7; k++) begin
      int dep;
      bit p, po, f, pop_ok, push_ok;
      logic [W-1:0] d;
      dep = (k == 6) ? 5 : 16;
      p   = (k == 6) ? s_push[0]  : push[k];
      po  = (k == 6) ? s_pop[0]   : pop[k];
      f   = (k == 6) ? s_flush[0] : flush[k];
      d   = (k == 6) ? s_din      : din[k*W +: W];
      if (f) begin
        mq[k].delete();
        movf[k] = 1'b0;
        mudf[k] = 1'b0;
      end else begin
        pop_ok  = po && (mq[k].size() != 0);
        push_ok = p && ((mq[k].size() != dep) || pop_ok);
        if (pop_ok)  void'(mq[k].pop_front());
        if (push_ok) mq[k].push_back(d);
        if (p && !push_ok) movf[k] = 1'b1;
        if (po && !pop_ok) mudf[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 7; k++) begin
      int sz, dep, th;
      logic o_p, o_f, o_af, o_ov, o_ud;
      logic [W-1:0] o_c, o_d;
      sz  = mq[k].size();
      dep = (k == 6) ? 5 : 16;
      th  = (k == 6) ? 3 : 14;
      if (k == 6) begin
        o_p = s_pndng[0]; o_f = s_full[0]; o_af = s_afull[0]; o_ov = s_ovf[0]; o_ud = s_udf[0];
        o_c = W'(s_cnt); o_d = s_dout;
      end else begin
        o_p = pndng[k]; o_f = full[k]; o_af = afull[k]; o_ov = ovf[k]; o_ud = udf[k];
        o_c = W'(cnt[k*CW +: CW]); o_d = dout[k*W +: W];
      end
      chk("pndng", k, W'(o_p),  W'(sz != 0));
      chk("full",  k, W'(o_f),  W'(sz == dep));
      chk("afull", k, W'(o_af), W'(sz >= th));
      chk("count", k, o_c,      W'(sz));
      chk("ovf",   k, W'(o_ov), W'(movf[k]));
      chk("udf",   k, W'(o_ud), W'(mudf[k]));
      if (sz != 0) chk("data", k, o_d, mq[k][0]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pndng"}, 0, W'(pndng), '0);
    chk({tag, "_full"},  0, W'(full),  '0);
    chk({tag, "_afull"}, 0, W'(afull), '0);
    chk({tag, "_count"}, 0, W'(cnt),   '0);
    chk({tag, "_ovf"},   0, W'(ovf),   '0);
    chk({tag, "_udf"},   0, W'(udf),   '0);
    for (int c = 0; c < NCH; c++) chk({tag, "_data"}, c, dout[c*W +: W], '0);
    chk({tag, "_s_pndng"}, 6, W'(s_pndng), '0);
    chk({tag, "_s_count"}, 6, W'(s_cnt),   '0);
    chk({tag, "_s_data"},  6, s_dout,      '0);
  endtask

  // Inputs are set by the caller at a falling edge; sample at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    clear_inputs();
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Fill and drain channel 0
    for (int i = 1; i <= 16; i++) begin
      push[0] = 1'b1; din[0*W +: W] = W'(i);
      tick();
    end
    chk("fill_full", 0, W'(full[0]), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 0, dout[0 +: W], W'(i + 1));
      pop[0] = 1'b1;
      tick();
    end
    chk("drain_pndng", 0, W'(pndng[0]), 0);

    // Overflow on channel 2, then full push+pop
    for (int i = 0; i < 16; i++) begin
      push[2] = 1'b1; din[2*W +: W] = W'(32'h100 + i);
      tick();
    end
    push[2] = 1'b1; din[2*W +: W] = 32'hDEAD;
    tick();
    chk("ovf2", 2, W'(ovf[2]), 1);
    push[2] = 1'b1; pop[2] = 1'b1; din[2*W +: W] = 32'hBEEF;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("beef_last", 2, dout[2*W +: W], 32'hBEEF);
      pop[2] = 1'b1;
      tick();
    end

    // Simultaneous push+pop on empty channel 1
    push[1] = 1'b1; pop[1] = 1'b1; din[1*W +: W] = 32'hA5;
    tick();
    chk("udf1_data", 1, dout[1*W +: W], 32'hA5);

    // Wrap-around on the depth-5 channel at occupancy 3
    for (int i = 0; i < 3; i++) begin
      s_push = 1'b1; s_din = W'(32'h50 + i);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      s_push = 1'b1; s_pop = 1'b1; s_din = W'(32'h60 + i);
      tick();
    end
    chk("wrap_count", 6, W'(s_cnt), 3);
    for (int i = 0; i < 4; i++) begin
      s_pop = 1'b1;
      tick();
    end

    // Flush isolation: ch4 at 7 with ovf set, ch5 at 2
    for (int i = 0; i < 17; i++) begin
      push[4] = 1'b1; din[4*W +: W] = W'(32'h400 + i);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      pop[4] = 1'b1;
      if (i < 2) begin push[5] = 1'b1; din[5*W +: W] = W'(32'h500 + i); end
      tick();
    end
    flush[4] = 1'b1; push[4] = 1'b1; din[4*W +: W] = 32'h4FF;
    tick();
    chk("flush_count", 4, W'(cnt[4*CW +: CW]), 0);
    chk("flush_ch5",   5, W'(cnt[5*CW +: CW]), 2);

    // Asynchronous reset mid-traffic with channel 3 at count 5
    for (int i = 0; i < 5; i++) begin
      push[3] = 1'b1; din[3*W +: W] = W'(32'h300 + i);
      tick();
    end
    push[3] = 1'b1; din[3*W +: W] = 32'h3FF;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    check_all();

    // Random traffic: a fill-biased phase then a drain-biased phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 200; i++) begin
        int pp, qp;
        pp = (ph == 0) ? 80 : 35;
        qp = (ph == 0) ? 30 : 70;
        for (int c = 0; c < NCH; c++) begin
          push[c]  = ($urandom_range(0, 99) < pp);
          pop[c]   = ($urandom_range(0, 99) < qp);
          flush[c] = ($urandom_range(0, 63) == 0);
          din[c*W +: W] = $urandom;
        end
        s_push  = ($urandom_range(0, 99) < pp);
        s_pop   = ($urandom_range(0, 99) < qp);
        s_flush = ($urandom_range(0, 63) == 0);
        s_din   = $urandom;
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
